// File: rtl/float_max_reduce_if.sv
// ---------------------------------------------------------------------------
// float_max_reduce_if
// Stream/configuration bundle for the float_max_reduce stage.
//
// Signals:
//   running    accelerator running; the stage advances only while high
//   run        one-cycle start pulse; latches configuration, restarts stage
//   in0        binary32 input sample
//   delay0     cycles to skip after run before the first sample is consumed
//   window     samples per window (0 behaves as 1)
//   out0       max of the last completed window, held between windows
//   out_valid  one-cycle pulse in the cycle out0 updates
//
// Modports:
//   master  drives stimulus/configuration, observes the result
//   slave   the reduction stage itself
// ---------------------------------------------------------------------------
interface float_max_reduce_if #(
    parameter int DATA_W  = 32,
    parameter int DELAY_W = 16,
    parameter int LEN_W   = 16
);
    logic               running;
    logic               run;
    logic [DATA_W-1:0]  in0;
    logic [DELAY_W-1:0] delay0;
    logic [LEN_W-1:0]   window;
    logic [DATA_W-1:0]  out0;
    logic               out_valid;

    modport master (
        output running, run, in0, delay0, window,
        input  out0, out_valid
    );

    modport slave (
        input  running, run, in0, delay0, window,
        output out0, out_valid
    );
endinterface

// File: rtl/float_max_reduce.sv
// ---------------------------------------------------------------------------
// float_max_reduce
// Streaming windowed max reduction over IEEE-754 binary32 samples. After a
// run pulse and a programmable start delay, every consecutive group of
// `window` samples is folded with an IEEE maxNum comparison and the result
// is published one cycle after the last sample of the group.
//
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset
//   bus   float_max_reduce_if.slave (running, run, in0, delay0, window in;
//         out0, out_valid out)
// ---------------------------------------------------------------------------
module float_max_reduce #(
    parameter int DATA_W  = 32,
    parameter int DELAY_W = 16,
    parameter int LEN_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    float_max_reduce_if.slave bus
);

    localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCUM
    } stateT;

    stateT              r_state;
    logic [DELAY_W-1:0] r_delayCount;
    logic [LEN_W-1:0]   r_window;
    logic [LEN_W-1:0]   r_sampleCount;
    logic [DATA_W-1:0]  r_acc;
    logic               r_accValid;
    logic [DATA_W-1:0]  r_out;
    logic               r_outValid;

    logic [LEN_W-1:0]   w_sampleCountNext;
    logic [DATA_W-1:0]  w_accNext;
    logic               w_accValidNext;
    logic               w_windowDone;
    logic [DATA_W-1:0]  w_result;

    // A NaN has an all-ones exponent and a non-zero mantissa; infinities
    // (zero mantissa) are ordinary ordered values here.
    function automatic logic isNaN(input logic [DATA_W-1:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // Sign-magnitude ordering on raw bits. Differing signs: the positive one
    // wins, which also makes +0 beat -0. Same sign: larger magnitude wins for
    // positives, smaller magnitude wins for negatives. Denormals fall out of
    // the plain magnitude compare with no flushing.
    function automatic logic isGreater(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
        if (a[31] != b[31])
            return !a[31];
        else if (!a[31])
            return a[30:0] > b[30:0];
        else
            return a[30:0] < b[30:0];
    endfunction

    // Fold the current sample into the accumulator. NaN samples are skipped
    // entirely, so the accumulator only ever holds ordered values and an
    // all-NaN window leaves it empty. The window is complete when this
    // sample brings the count up to the latched length.
    always_comb begin
        w_accNext         = r_acc;
        w_accValidNext    = r_accValid;
        w_sampleCountNext = r_sampleCount + LEN_W'(1);
        if (!isNaN(bus.in0)) begin
            if (!r_accValid || isGreater(bus.in0, r_acc))
                w_accNext = bus.in0;
            w_accValidNext = 1'b1;
        end
        w_windowDone = (w_sampleCountNext == r_window);
        w_result     = w_accValidNext ? w_accNext : QNAN;
    end

    // Control and datapath state. run restarts the stage from any state and
    // suppresses a window that would otherwise complete in the same cycle.
    // With running low nothing moves and out_valid stays low. The delay
    // counter reaching zero only switches to ACCUM; the first sample is taken
    // on the following running cycle, giving delay0+1 cycles from run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_delayCount  <= '0;
            r_window      <= '0;
            r_sampleCount <= '0;
            r_acc         <= '0;
            r_accValid    <= 1'b0;
            r_out         <= '0;
            r_outValid    <= 1'b0;
        end else begin
            r_outValid <= 1'b0;
            if (bus.run) begin
                r_delayCount  <= bus.delay0;
                r_window      <= (bus.window == '0) ? LEN_W'(1) : bus.window;
                r_sampleCount <= '0;
                r_accValid    <= 1'b0;
                r_state       <= (bus.delay0 != '0) ? WAIT : ACCUM;
            end else if (bus.running) begin
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    WAIT: begin
                        r_delayCount <= r_delayCount - DELAY_W'(1);
                        if (r_delayCount == DELAY_W'(1))
                            r_state <= ACCUM;
                    end
                    ACCUM: begin
                        if (w_windowDone) begin
                            r_out         <= w_result;
                            r_outValid    <= 1'b1;
                            r_sampleCount <= '0;
                            r_accValid    <= 1'b0;
                        end else begin
                            r_sampleCount <= w_sampleCountNext;
                            r_acc         <= w_accNext;
                            r_accValid    <= w_accValidNext;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.out0      = r_out;
    assign bus.out_valid = r_outValid;

endmodule

// File: tb/tb_float_max_reduce.sv
// ---------------------------------------------------------------------------
// tb_float_max_reduce
// Scoreboard bench for float_max_reduce. Each expected window maximum is
// pushed when the last sample of its window is driven; a monitor pops and
// compares on every out_valid pulse, so an extra or missing pulse shows up.
// ---------------------------------------------------------------------------
module tb_float_max_reduce;

    logic clk = 1'b0;
    logic rst;

    float_max_reduce_if #(.DATA_W(32), .DELAY_W(16), .LEN_W(16)) bus ();

    float_max_reduce #(.DATA_W(32), .DELAY_W(16), .LEN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] expQ[$];
    logic [31:0] expVal;
    int compareCount  = 0;
    int mismatchCount = 0;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // One comparison: count it, report it if it differs.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge so they are stable
    // at the next one; run is always dropped again afterwards.
    task automatic applyStimulus(input logic runPulse, input logic runningIn,
                                 input logic [31:0] sample);
        bus.run     = runPulse;
        bus.running = runningIn;
        bus.in0     = sample;
        @(posedge clk);
        #1;
        bus.run = 1'b0;
    endtask

    task automatic startRun(input logic [15:0] d, input logic [15:0] w);
        bus.delay0 = d;
        bus.window = w;
        applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF);
    endtask

    task automatic feed(input logic [31:0] sample);
        applyStimulus(1'b0, 1'b1, sample);
    endtask

    task automatic feedLast(input logic [31:0] sample, input logic [31:0] expected);
        expQ.push_back(expected);
        applyStimulus(1'b0, 1'b1, sample);
    endtask

    task automatic pause(input int n, input logic [31:0] sample);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, sample);
    endtask

    // Every out_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_valid", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                expVal = expQ.pop_front();
                checkOutput("window_max", bus.out0, expVal);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.run     = 1'b0;
        bus.running = 1'b0;
        bus.in0     = 32'd0;
        bus.delay0  = 16'd0;
        bus.window  = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset: nothing happens even with running high.
        for (int i = 0; i < 5; i++) begin
            checkOutput("idle_out0", bus.out0, 32'h0000_0000);
            checkOutput("idle_valid", {31'd0, bus.out_valid}, 32'd0);
            feed(32'h3F80_0000);
        end

        // Basic window of 4, no delay.
        startRun(16'd0, 16'd4);
        feed(32'h3F80_0000);
        feed(32'hC040_0000);
        feed(32'h4000_0000);
        feedLast(32'h3F00_0000, 32'h4000_0000);
        pause(3, 32'h0);

        // Start delay of 3 skips the first three samples.
        startRun(16'd3, 16'd2);
        feed(32'h4110_0000);
        feed(32'h4110_0000);
        feed(32'h4110_0000);
        feed(32'h3F80_0000);
        feedLast(32'h3F00_0000, 32'h3F80_0000);
        pause(2, 32'h0);

        // Back-to-back windows of 3: signed zeros, NaN skipping, all-NaN,
        // denormals vs -Inf, and +Inf vs max finite.
        startRun(16'd0, 16'd3);
        feed(32'h8000_0000);
        feed(32'h0000_0000);
        feedLast(32'hBF80_0000, 32'h0000_0000);
        feed(32'h7FC0_0001);
        feed(32'hC000_0000);
        feedLast(32'h7F80_0001, 32'hC000_0000);
        feed(32'h7FC0_0001);
        feed(32'hFFC0_0000);
        feedLast(32'h7F80_0005, 32'h7FC0_0000);
        feed(32'h0000_0001);
        feed(32'hFF80_0000);
        feedLast(32'h0000_0002, 32'h0000_0002);
        feed(32'h7F80_0000);
        feed(32'h7F7F_FFFF);
        feedLast(32'h7FC0_0000, 32'h7F80_0000);
        pause(2, 32'h0);

        // window=0 behaves as 1: every sample is its own window.
        startRun(16'd0, 16'd0);
        feedLast(32'h4040_0000, 32'h4040_0000);
        feedLast(32'hC120_0000, 32'hC120_0000);
        feedLast(32'h3E80_0000, 32'h3E80_0000);
        pause(2, 32'h0);

        // running drops mid-window; the 100.0 presented meanwhile is ignored.
        startRun(16'd0, 16'd4);
        feed(32'h3F80_0000);
        feed(32'h40A0_0000);
        pause(3, 32'h42C8_0000);
        feed(32'h4000_0000);
        feedLast(32'h4040_0000, 32'h40A0_0000);
        pause(2, 32'h0);

        // run mid-window discards the partial window.
        startRun(16'd0, 16'd4);
        feed(32'h40E0_0000);
        feed(32'h4100_0000);
        startRun(16'd0, 16'd2);
        feed(32'h3F80_0000);
        feedLast(32'h3F00_0000, 32'h3F80_0000);
        pause(1, 32'h0);

        // run coinciding with window completion wins: no result for 6.0.
        startRun(16'd0, 16'd2);
        feed(32'h40C0_0000);
        startRun(16'd0, 16'd2);
        feed(32'h3F00_0000);
        feedLast(32'h3E80_0000, 32'h3F00_0000);
        pause(2, 32'h0);

        // Reset mid-window clears out0 and returns to IDLE.
        startRun(16'd0, 16'd4);
        feed(32'h4000_0000);
        feed(32'h4040_0000);
        rst = 1'b1;
        feed(32'h4080_0000);
        rst = 1'b0;
        checkOutput("rst_out0", bus.out0, 32'h0000_0000);
        checkOutput("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        for (int i = 0; i < 5; i++)
            feed(32'h4110_0000);
        pause(2, 32'h0);
        checkOutput("idle_after_rst_out0", bus.out0, 32'h0000_0000);

        checkOutput("queue_drained", expQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
